// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp
//   Drives the compare input of the downstream pwm block. A request supplies
//   a target duty, a per-step increment and a number of PWM periods between
//   steps; compare then walks towards the target, changing only on the last
//   cycle of a PWM period so the pwm never emits a truncated period.
//
// Ports
//   clk           system clock, shared with the downstream pwm
//   rst           asynchronous reset, active low
//   target_valid  request to start a ramp
//   target_ready  block can accept a request (IDLE)
//   target        final duty value
//   step          duty increment per step (0 treated as 1)
//   rate_div      PWM periods between steps (0 treated as 1)
//   compare       current duty, to pwm.compare
//   period_end    high on the last cycle of each PWM period
//   busy          ramp in progress
//   done          one-cycle pulse when compare reaches target
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request, target_ready=1, busy=0
// RAMP  | stepping compare towards the latched target, busy=1

module pwm_duty_ramp #(
    parameter int CTR_LEN = 8,
    parameter int DIV_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               target_valid,
    output logic               target_ready,
    input  logic [CTR_LEN-1:0] target,
    input  logic [CTR_LEN-1:0] step,
    input  logic [DIV_LEN-1:0] rate_div,
    output logic [CTR_LEN-1:0] compare,
    output logic               period_end,
    output logic               busy,
    output logic               done
);

    typedef enum logic {IDLE, RAMP} state_t;

    localparam logic [CTR_LEN-1:0] CTR_ONE = 1;
    localparam logic [DIV_LEN-1:0] DIV_ONE = 1;
    localparam logic [DIV_LEN:0]   DIV_ONE_W = 1;

    state_t             state;
    logic [CTR_LEN-1:0] ctr;
    logic [CTR_LEN-1:0] target_q;
    logic [CTR_LEN-1:0] step_q;
    logic [DIV_LEN-1:0] rate_div_q;
    logic [DIV_LEN-1:0] rate_cnt;

    logic [DIV_LEN:0]   rate_next;
    logic               step_fire;
    logic [CTR_LEN:0]   sum;
    logic [CTR_LEN:0]   diff;
    logic [CTR_LEN-1:0] next_compare;

    // Free-running period counter, phase-aligned with the downstream pwm.
    assign period_end = &ctr;

    assign rate_next = {1'b0, rate_cnt} + DIV_ONE_W;
    assign step_fire = (state == RAMP) && period_end
                       && (rate_next == {1'b0, rate_div_q});

    // One extra bit catches carry-out above all-ones and borrow below zero.
    assign sum  = {1'b0, compare} + {1'b0, step_q};
    assign diff = {1'b0, compare} - {1'b0, step_q};

    always_comb begin
        next_compare = compare;
        if (compare < target_q) begin
            if (sum > {1'b0, target_q})
                next_compare = target_q;
            else
                next_compare = sum[CTR_LEN-1:0];
        end else if (compare > target_q) begin
            if (diff[CTR_LEN] || (diff[CTR_LEN-1:0] < target_q))
                next_compare = target_q;
            else
                next_compare = diff[CTR_LEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            ctr          <= '0;
            compare      <= '0;
            target_q     <= '0;
            step_q       <= CTR_ONE;
            rate_div_q   <= DIV_ONE;
            rate_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            target_ready <= 1'b0;
        end else begin
            ctr  <= ctr + CTR_ONE;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    target_ready <= 1'b1;
                    busy         <= 1'b0;
                    if (target_valid && target_ready) begin
                        target_q   <= target;
                        step_q     <= (step == '0) ? CTR_ONE : step;
                        rate_div_q <= (rate_div == '0) ? DIV_ONE : rate_div;
                        rate_cnt   <= '0;
                        if (target == compare) begin
                            done <= 1'b1;
                        end else begin
                            state        <= RAMP;
                            busy         <= 1'b1;
                            target_ready <= 1'b0;
                        end
                    end
                end
                RAMP: begin
                    if (period_end) begin
                        if (step_fire) begin
                            compare  <= next_compare;
                            rate_cnt <= '0;
                            if (next_compare == target_q) begin
                                done         <= 1'b1;
                                state        <= IDLE;
                                busy         <= 1'b0;
                                target_ready <= 1'b1;
                            end
                        end else begin
                            rate_cnt <= rate_next[DIV_LEN-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
module tb_pwm_duty_ramp;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       target_valid = 1'b0;
    logic       target_ready;
    logic [7:0] target = '0;
    logic [7:0] step = '0;
    logic [15:0] rate_div = '0;
    logic [7:0] compare;
    logic       period_end;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;
    int cyc;        // clk edges since reset release: model of the period phase
    int model_cmp;  // duty the model believes compare holds

    pwm_duty_ramp #(.CTR_LEN(8), .DIV_LEN(16)) dut (
        .clk(clk), .rst(rst),
        .target_valid(target_valid), .target_ready(target_ready),
        .target(target), .step(step), .rate_div(rate_div),
        .compare(compare), .period_end(period_end),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic test_reset();
        int first_pe;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (compare !== 8'd0) begin bad++; $display("FAIL reset_compare got=%0d exp=0", compare); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (target_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", target_ready); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (target_ready !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b exp=0", target_ready); end
        @(posedge clk); #1;
        total++; if (target_ready !== 1'b1) begin bad++; $display("FAIL ready_after_edge got=%b exp=1", target_ready); end
        // period_end must first rise 255 edges after release
        first_pe = -1;
        for (int c = 1; c < 600 && first_pe < 0; c++) begin
            if (period_end === 1'b1) first_pe = c;
            @(posedge clk); #1;
        end
        total++; if (first_pe != 255) begin bad++; $display("FAIL first_period_end got=%0d exp=255", first_pe); end
        model_cmp = 0;
    endtask

    // Starts one ramp and follows it edge by edge against the model.
    task automatic run_ramp(input string name, input int tgt, input int stp,
                            input int rd, input bit poke);
        int seq[$];
        int cur, s_eff, rd_eff, pe_cnt, k, exp_cmp, limit;
        bit pe_now, exp_done;
        s_eff  = (stp == 0) ? 1 : stp;
        rd_eff = (rd == 0) ? 1 : rd;
        cur = model_cmp;
        while (cur != tgt) begin
            if (cur < tgt) cur = (cur + s_eff > tgt) ? tgt : cur + s_eff;
            else           cur = (cur - s_eff < tgt) ? tgt : cur - s_eff;
            seq.push_back(cur);
        end

        @(negedge clk);
        total++; if (target_ready !== 1'b1) begin bad++; $display("FAIL %s ready_idle got=%b exp=1", name, target_ready); end
        target_valid = 1'b1; target = tgt[7:0]; step = stp[7:0]; rate_div = rd[15:0];
        @(posedge clk); #1;
        target_valid = 1'b0;

        if (seq.size() == 0) begin
            total++; if (done !== 1'b1) begin bad++; $display("FAIL %s eq_done got=%b exp=1", name, done); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s eq_busy got=%b exp=0", name, busy); end
            total++; if (compare !== tgt[7:0]) begin bad++; $display("FAIL %s eq_compare got=%0d exp=%0d", name, compare, tgt); end
            @(posedge clk); #1;
            total++; if (done !== 1'b0) begin bad++; $display("FAIL %s eq_done_clear got=%b exp=0", name, done); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s eq_busy_after got=%b exp=0", name, busy); end
            return;
        end

        total++; if (busy !== 1'b1 || target_ready !== 1'b0) begin
            bad++; $display("FAIL %s start busy=%b ready=%b exp busy=1 ready=0", name, busy, target_ready);
        end

        pe_cnt = 0; k = 0;
        limit = (seq.size() * rd_eff + 2) * 256 + 10;
        for (int c = 0; c < limit && k < seq.size(); c++) begin
            @(negedge clk);
            pe_now = ((cyc % 256) == 255);
            if (period_end !== pe_now) begin
                total++; bad++;
                $display("FAIL %s period_end cyc=%0d got=%b exp=%b", name, cyc, period_end, pe_now);
            end
            if (poke && c == 100) begin
                target_valid = 1'b1; target = 8'(tgt ^ 8'h55); step = 8'd1; rate_div = 16'd1;
            end
            if (poke && c == 101) target_valid = 1'b0;
            @(posedge clk); #1;
            exp_done = 1'b0;
            if (pe_now) begin
                pe_cnt++;
                if (pe_cnt % rd_eff == 0) begin
                    k++;
                    exp_done = (k == seq.size());
                end
            end
            exp_cmp = (k == 0) ? model_cmp : seq[k-1];
            total++;
            if (compare !== exp_cmp[7:0] || done !== exp_done || busy !== !exp_done
                || target_ready !== exp_done) begin
                bad++;
                $display("FAIL %s cycle=%0d compare=%0d done=%b busy=%b ready=%b exp compare=%0d done=%b busy=%b ready=%b",
                         name, c, compare, done, busy, target_ready, exp_cmp, exp_done, !exp_done, exp_done);
            end
        end
        total++; if (k != seq.size()) begin bad++; $display("FAIL %s timeout steps=%0d exp=%0d", name, k, seq.size()); end
        @(posedge clk); #1;
        total++; if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL %s after_done done=%b busy=%b exp 0 0", name, done, busy);
        end
        model_cmp = tgt;
    endtask

    task automatic test_up_ramp();
        run_ramp("up_ramp", 128, 16, 1, 1'b0);
    endtask

    task automatic test_down_clamp();
        run_ramp("down_clamp", 30, 50, 2, 1'b0);
    endtask

    task automatic test_overflow_guard();
        run_ramp("to_250", 250, 255, 1, 1'b0);
        run_ramp("ovf_255", 255, 10, 1, 1'b0);
        run_ramp("to_5", 5, 255, 1, 1'b0);
        run_ramp("udf_0", 0, 10, 1, 1'b0);
    endtask

    task automatic test_degenerate();
        run_ramp("zero_step_rate", 3, 0, 0, 1'b0);
        run_ramp("equal_target", 3, 7, 4, 1'b0);
    endtask

    task automatic test_ignore_during_ramp();
        run_ramp("poke_ramp", 200, 40, 2, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            run_ramp("random", int'($urandom_range(0, 255)), int'($urandom_range(32, 255)),
                     int'($urandom_range(0, 3)), 1'(i % 2));
        end
    endtask

    task automatic test_reset_mid_ramp();
        @(negedge clk);
        target_valid = 1'b1;
        target = (model_cmp < 128) ? 8'd255 : 8'd0;
        step = 8'd1; rate_div = 16'd1;
        @(posedge clk); #1;
        target_valid = 1'b0;
        repeat (300) @(posedge clk);
        #3;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midreset_busy_before got=%b exp=1", busy); end
        rst = 1'b0;
        #1;
        total++; if (compare !== 8'd0) begin bad++; $display("FAIL midreset_compare got=%0d exp=0", compare); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        total++; if (target_ready !== 1'b0) begin bad++; $display("FAIL midreset_ready got=%b exp=0", target_ready); end
        @(negedge clk);
        rst = 1'b1;
        model_cmp = 0;
        run_ramp("after_reset", 64, 32, 1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_up_ramp();
        test_down_clamp();
        test_overflow_guard();
        test_degenerate();
        test_ignore_during_ramp();
        test_random();
        test_reset_mid_ramp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_duty_ramp.md
Name: pwm_duty_ramp

Overview:
- Upstream companion to the `pwm` block. Drives its `compare` input.
- Accepts a target duty value and moves `compare` towards it in fixed steps.
- `compare` changes only at PWM period boundaries, so the PWM output never produces a glitched or truncated period.
- Use: LED fades and soft-start motor drive.

Parameters:
- CTR_LEN, 8: width of `compare`/`target`; must match the downstream `pwm` CTR_LEN.
- DIV_LEN, 16: width of the `rate_div` field (PWM periods per step).

Ports:
- clk  input  1  system clock; the same clock drives the downstream pwm.
- rst  input  1  reset, asynchronous, active-low.
- target_valid  input  1  request to start a ramp.
- target_ready  output  1  block can accept a request.
- target  input  CTR_LEN  final duty value.
- step  input  CTR_LEN  duty increment applied per step.
- rate_div  input  DIV_LEN  number of PWM periods between steps.
- compare  output  CTR_LEN  current duty, fed to `pwm.compare`.
- period_end  output  1  high on the last cycle of each PWM period.
- busy  output  1  a ramp is in progress.
- done  output  1  one-cycle pulse when `compare` reaches `target`.

Behaviour:
- Reset (rst low, asynchronous):
  - compare=0, internal period counter ctr=0, rate counter=0.
  - state=IDLE, busy=0, done=0, target_ready=0.
  - Reset asserted mid-ramp aborts the ramp immediately.
  - target_ready rises on the first clk edge after rst deasserts.
- Period counter:
  - ctr is a free-running CTR_LEN-bit counter, +1 every clk, wraps from 2^CTR_LEN-1 to 0.
  - It starts at 0 out of reset, the same as the downstream pwm, so the two stay phase-aligned.
  - period_end = (ctr == all ones), combinational from ctr.
- States:
  - IDLE: target_ready=1, busy=0.
  - RAMP: target_ready=0, busy=1.
- Accept: target_valid && target_ready on a clk edge. On that edge:
  - Latch target, step and rate_div. A step value of 0 is latched as 1; a rate_div value of 0 is latched as 1.
  - Clear the rate counter.
  - If the latched target equals compare: stay in IDLE and pulse done on the next cycle. compare does not change.
  - Otherwise: go to RAMP (busy=1 from the next cycle).
- target_valid while in RAMP is ignored (target_ready=0). A request held high is accepted on the cycle after done.
- Rate counter in RAMP:
  - Increments on each period_end cycle.
  - When it would reach the latched rate_div on a period_end cycle, a step fires and the counter returns to 0.
  - The first step fires on the rate_div-th period_end after accept. A period_end on the accept cycle itself does not count.
- Step arithmetic (evaluated in CTR_LEN+1 bits, no wrap-around):
  - If compare < target: compare = min(compare + step, target).
  - If compare > target: compare = max(compare - step, target). Compute using a borrow check, never wrap below 0.
  - compare is registered on the step edge, so the new value is visible from ctr==0 of the next period.
- Completion:
  - On the step edge where the new compare equals target: done=1 for exactly one cycle (registered with compare), and state returns to IDLE.
  - Because the transition happens on that same edge, busy=0 and target_ready=1 on the cycle after the edge.
- compare never changes except on a step edge or on reset.

Test Plan:
- Reset: rst=0 for 2 clk -> compare=0, busy=0, done=0, target_ready=0. Release -> target_ready=1 after one clk; period_end high every 256 clk starting at clk 255.
- Up ramp: target=128, step=16, rate_div=1 from compare=0 -> compare takes 16, 32, …, 128 at 8 consecutive period_end edges. done pulses once with compare=128; busy falls on the following cycle.
- Down ramp with clamp: from 128, target=30, step=50, rate_div=2 -> compare becomes 78 after the 2nd period_end, then 30 after the 4th (clamped, not 28); done pulses once.
- Overflow/underflow guard:
  - From 250, target=255, step=10 -> compare=255 in one step, never wraps to 4.
  - From 5, target=0, step=10 -> compare=0, never wraps to 251.
- Degenerate inputs:
  - step=0, rate_div=0, target=3 from 0 -> compare steps 1, 2, 3 at consecutive period_ends.
  - target equal to current compare -> no RAMP, done pulses on the next cycle, busy stays 0.
- Handshake and reset mid-op:
  - target_valid pulsed during RAMP -> ignored; the original ramp completes unchanged.
  - rst driven low mid-ramp between clk edges -> compare=0 and busy=0 immediately, without waiting for a clk edge.
